// File: rtl/systolic_feeder_pkg.sv
// Shared types and derived timing constants for the systolic operand feeder.
package systolic_feeder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DRAIN = 2'd2,
    ST_FIN   = 2'd3
  } fsm_state_t;

  // LSB of lane 'lane' in a bus packed as Bitwidth-wide lanes.
  function automatic int lane_lsb(input int lane, input int width);
    return lane * width;
  endfunction

  // Minimum DRAIN dwell: one cycle per array edge lane.
  function automatic int drain_len(input int ux, input int uy);
    return ux + uy;
  endfunction

  // Cycles for partial sums to leave the array once its far corner is fed.
  function automatic int flush_len(input int ux, input int uy);
    return ux + uy - 1;
  endfunction

  // ARRAY_EN hold after the last skew stage empties: the far-corner fill time
  // not already covered by the longest skew line, plus the array flush.
  function automatic int array_tail(input int ux, input int uy);
    int skew_max;
    skew_max = ((ux > uy) ? ux : uy) - 1;
    return (ux - 1) + (uy - 1) - skew_max + flush_len(ux, uy);
  endfunction

  // Cycles from START sampled in IDLE to the DONE pulse.
  function automatic int run_latency(input int ux, input int uy, input int depth);
    return 3 + depth + (ux - 1) + (uy - 1) + flush_len(ux, uy);
  endfunction

endpackage

// File: rtl/systolic_feeder_if.sv
// Handshake, ROM and array-edge signals of the systolic operand feeder.
interface systolic_feeder_if #(
  parameter int UNITS_X  = 2,
  parameter int UNITS_Y  = 2,
  parameter int Bitwidth = 16,
  parameter int ADDR_W   = 8
);
  logic                          START;
  logic                          ROM_EN;
  logic [ADDR_W-1:0]             ROM_ADDR;
  logic [Bitwidth*UNITS_X-1:0]   WT_DATA;
  logic [Bitwidth*UNITS_Y-1:0]   IN_DATA;
  logic [Bitwidth*UNITS_X-1:0]   WT_OUT;
  logic [Bitwidth*UNITS_Y-1:0]   IN_OUT;
  logic                          ARRAY_EN;
  logic                          BUSY;
  logic                          DONE;

  // Feeder side.
  modport master (
    input  START, WT_DATA, IN_DATA,
    output ROM_EN, ROM_ADDR, WT_OUT, IN_OUT, ARRAY_EN, BUSY, DONE
  );

  // Controller / ROM / array side.
  modport slave (
    output START, WT_DATA, IN_DATA,
    input  ROM_EN, ROM_ADDR, WT_OUT, IN_OUT, ARRAY_EN, BUSY, DONE
  );
endinterface

// File: rtl/systolic_feeder_skew_line.sv
// One operand lane: capture register plus STAGES delay stages of {valid, word},
// with the output forced to zero whenever the last stage is not valid.
module systolic_feeder_skew_line #(
  parameter int Bitwidth = 16,
  parameter int STAGES   = 0
) (
  input  logic                CLK,
  input  logic                RST_N,
  input  logic                vld_i,
  input  logic [Bitwidth-1:0] word_i,
  output logic [Bitwidth-1:0] word_o,
  output logic                any_vld_o
);

  logic                vld_q  [STAGES+1];
  logic [Bitwidth-1:0] word_q [STAGES+1];
  logic [STAGES:0]     vld_vec;

  // Capture stage: register ROM data alongside its valid bit; invalid words stored as zero.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      vld_q[0]  <= 1'b0;
      word_q[0] <= '0;
    end else begin
      vld_q[0]  <= vld_i;
      word_q[0] <= vld_i ? word_i : '0;
    end
  end

  assign vld_vec[0] = vld_q[0];

  for (genvar s = 1; s <= STAGES; s++) begin : g_stage
    // Skew stage s: shift {valid, word} one cycle further.
    always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
        vld_q[s]  <= 1'b0;
        word_q[s] <= '0;
      end else begin
        vld_q[s]  <= vld_q[s-1];
        word_q[s] <= word_q[s-1];
      end
    end
    assign vld_vec[s] = vld_q[s];
  end

  assign word_o    = vld_q[STAGES] ? word_q[STAGES] : '0;
  assign any_vld_o = |vld_vec;

endmodule

// File: rtl/systolic_feeder.sv
// Operand feeder: walks the ROM address range, skews the returned weight/input
// lanes diagonally, and generates ARRAY_EN plus a DONE pulse per run.
module systolic_feeder
  import systolic_feeder_pkg::*;
#(
  parameter int UNITS_X  = 2,
  parameter int UNITS_Y  = 2,
  parameter int Bitwidth = 16,
  parameter int DEPTH    = 4,
  parameter int ADDR_W   = 8
) (
  input logic               CLK,
  input logic               RST_N,
  systolic_feeder_if.master bus
);

  localparam int                TAIL      = array_tail(UNITS_X, UNITS_Y);
  localparam int                HOLD_W    = $clog2(TAIL + 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  if (DEPTH < 1 || DEPTH > 255 || DEPTH > (2 ** ADDR_W)) begin : g_bad_depth
    $fatal(1, "systolic_feeder: DEPTH=%0d not addressable with ADDR_W=%0d", DEPTH, ADDR_W);
  end

  fsm_state_t                  state_q, state_d;
  logic [ADDR_W-1:0]           addr_q, addr_d;
  logic                        rom_vld_q;
  logic [HOLD_W-1:0]           hold_q, hold_d;
  logic [UNITS_X-1:0]          wt_vld;
  logic [UNITS_Y-1:0]          in_vld;
  logic                        any_vld;
  logic                        tail_last;
  logic [Bitwidth*UNITS_X-1:0] wt_out;
  logic [Bitwidth*UNITS_Y-1:0] in_out;

  // State, address counter, ROM-data valid and ARRAY_EN hold counter.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q   <= ST_IDLE;
      addr_q    <= '0;
      rom_vld_q <= 1'b0;
      hold_q    <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      rom_vld_q <= (state_q == ST_FETCH);
      hold_q    <= hold_d;
    end
  end

  // Next state and address.
  // DRAIN exits on the final tail cycle of ARRAY_EN rather than after a fixed
  // drain_len() count, so DONE always lands the cycle after ARRAY_EN falls.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.START) begin
          state_d = ST_FETCH;
          addr_d  = '0;
        end
      end
      ST_FETCH: begin
        if (addr_q == LAST_ADDR) begin
          state_d = ST_DRAIN;
          addr_d  = '0;
        end else begin
          addr_d = addr_q + 1'b1;
        end
      end
      ST_DRAIN: begin
        if (tail_last) state_d = ST_FIN;
      end
      ST_FIN:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // ARRAY_EN hold: reload while any lane holds data, then count the tail down.
  always_comb begin
    hold_d = hold_q;
    if (any_vld)            hold_d = HOLD_W'(TAIL);
    else if (hold_q != '0)  hold_d = hold_q - 1'b1;
  end

  assign any_vld   = (|wt_vld) | (|in_vld);
  assign tail_last = !any_vld && (hold_q == HOLD_W'(1));

  for (genvar j = 0; j < UNITS_X; j++) begin : g_wt
    systolic_feeder_skew_line #(.Bitwidth(Bitwidth), .STAGES(j)) u_line (
      .CLK       (CLK),
      .RST_N     (RST_N),
      .vld_i     (rom_vld_q),
      .word_i    (bus.WT_DATA[lane_lsb(j, Bitwidth) +: Bitwidth]),
      .word_o    (wt_out[lane_lsb(j, Bitwidth) +: Bitwidth]),
      .any_vld_o (wt_vld[j])
    );
  end

  for (genvar i = 0; i < UNITS_Y; i++) begin : g_in
    systolic_feeder_skew_line #(.Bitwidth(Bitwidth), .STAGES(i)) u_line (
      .CLK       (CLK),
      .RST_N     (RST_N),
      .vld_i     (rom_vld_q),
      .word_i    (bus.IN_DATA[lane_lsb(i, Bitwidth) +: Bitwidth]),
      .word_o    (in_out[lane_lsb(i, Bitwidth) +: Bitwidth]),
      .any_vld_o (in_vld[i])
    );
  end

  assign bus.ROM_EN   = (state_q == ST_FETCH);
  assign bus.ROM_ADDR = addr_q;
  assign bus.WT_OUT   = wt_out;
  assign bus.IN_OUT   = in_out;
  assign bus.ARRAY_EN = any_vld || (hold_q != '0);
  assign bus.BUSY     = (state_q == ST_FETCH) || (state_q == ST_DRAIN);
  assign bus.DONE     = (state_q == ST_FIN);

endmodule

// File: tb/tb_systolic_feeder.sv
// Directed bench for systolic_feeder: default config, a wide/shallow config and
// a narrow-address config, all sharing one clock and reset.
module tb_systolic_feeder;

  logic CLK = 1'b0;
  logic RST_N;
  logic rand_rom;
  int   checks = 0;
  int   errors = 0;

  always #5 CLK = ~CLK;

  systolic_feeder_if #(.UNITS_X(2), .UNITS_Y(2), .Bitwidth(16), .ADDR_W(8)) ifa ();
  systolic_feeder_if #(.UNITS_X(4), .UNITS_Y(3), .Bitwidth(16), .ADDR_W(8)) ifb ();
  systolic_feeder_if #(.UNITS_X(2), .UNITS_Y(2), .Bitwidth(16), .ADDR_W(2)) ifc ();

  systolic_feeder #(.UNITS_X(2), .UNITS_Y(2), .Bitwidth(16), .DEPTH(4), .ADDR_W(8))
    dut_a (.CLK(CLK), .RST_N(RST_N), .bus(ifa));
  systolic_feeder #(.UNITS_X(4), .UNITS_Y(3), .Bitwidth(16), .DEPTH(1), .ADDR_W(8))
    dut_b (.CLK(CLK), .RST_N(RST_N), .bus(ifb));
  systolic_feeder #(.UNITS_X(2), .UNITS_Y(2), .Bitwidth(16), .DEPTH(4), .ADDR_W(2))
    dut_c (.CLK(CLK), .RST_N(RST_N), .bus(ifc));

  // Synchronous ROM models: word = 10*lane + addr + 1 (inputs offset by 0x100).
  always @(posedge CLK) begin
    if (rand_rom) begin
      ifa.WT_DATA <= 32'($urandom);
      ifa.IN_DATA <= 32'($urandom);
    end else if (ifa.ROM_EN) begin
      for (int j = 0; j < 2; j++) begin
        ifa.WT_DATA[16*j +: 16] <= 16'(10*j + int'(ifa.ROM_ADDR) + 1);
        ifa.IN_DATA[16*j +: 16] <= 16'(256 + 10*j + int'(ifa.ROM_ADDR) + 1);
      end
    end
  end

  always @(posedge CLK) begin
    if (rand_rom) begin
      ifb.WT_DATA <= {$urandom, $urandom};
      ifb.IN_DATA <= 48'({$urandom, $urandom});
    end else if (ifb.ROM_EN) begin
      ifb.WT_DATA <= '1;
      ifb.IN_DATA <= '1;
    end
  end

  always @(posedge CLK) begin
    if (rand_rom) begin
      ifc.WT_DATA <= 32'($urandom);
      ifc.IN_DATA <= 32'($urandom);
    end else if (ifc.ROM_EN) begin
      for (int j = 0; j < 2; j++) begin
        ifc.WT_DATA[16*j +: 16] <= 16'(10*j + int'(ifc.ROM_ADDR) + 1);
        ifc.IN_DATA[16*j +: 16] <= 16'(256 + 10*j + int'(ifc.ROM_ADDR) + 1);
      end
    end
  end

  typedef struct {
    int start;
    int rom_en;
    int addr;
    int wt0, wt1, in0, in1;
    int aen, busy, done;
  } vec_t;

  vec_t tbl [14];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, " a data"}, 128'({ifa.WT_OUT, ifa.IN_OUT}), 128'(0));
    chk({tag, " a ctl"},  128'({ifa.ROM_EN, ifa.ROM_ADDR, ifa.ARRAY_EN, ifa.BUSY, ifa.DONE}), 128'(0));
    chk({tag, " b data"}, 128'({ifb.WT_OUT, ifb.IN_OUT}), 128'(0));
    chk({tag, " b ctl"},  128'({ifb.ROM_EN, ifb.ROM_ADDR, ifb.ARRAY_EN, ifb.BUSY, ifb.DONE}), 128'(0));
    chk({tag, " c data"}, 128'({ifc.WT_OUT, ifc.IN_OUT}), 128'(0));
    chk({tag, " c ctl"},  128'({ifc.ROM_EN, ifc.ROM_ADDR, ifc.ARRAY_EN, ifc.BUSY, ifc.DONE}), 128'(0));
  endtask

  // Apply the default-config table: entry c is cycle t0+c, sampled mid-cycle.
  task automatic run_table(input string tag);
    for (int c = 0; c < 14; c++) begin
      @(posedge CLK);
      #1 ifa.START = tbl[c].start[0];
      @(negedge CLK);
      chk($sformatf("%s c%0d rom_en", tag, c), 128'(ifa.ROM_EN), 128'(tbl[c].rom_en));
      chk($sformatf("%s c%0d addr", tag, c), 128'(ifa.ROM_ADDR), 128'(tbl[c].addr));
      chk($sformatf("%s c%0d wt", tag, c), 128'(ifa.WT_OUT),
          128'({16'(tbl[c].wt1), 16'(tbl[c].wt0)}));
      chk($sformatf("%s c%0d in", tag, c), 128'(ifa.IN_OUT),
          128'({16'(tbl[c].in1), 16'(tbl[c].in0)}));
      chk($sformatf("%s c%0d array_en", tag, c), 128'(ifa.ARRAY_EN), 128'(tbl[c].aen));
      chk($sformatf("%s c%0d busy", tag, c), 128'(ifa.BUSY), 128'(tbl[c].busy));
      chk($sformatf("%s c%0d done", tag, c), 128'(ifa.DONE), 128'(tbl[c].done));
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   done_cyc[$];
    int   addrs[$];
    int   fetch2;
    int   activity;

    //            start en addr wt0 wt1  in0    in1    aen busy done
    tbl[0]  = '{1, 0, 0, 0,  0,  0,     0,     0, 0, 0};
    tbl[1]  = '{0, 1, 0, 0,  0,  0,     0,     0, 1, 0};
    tbl[2]  = '{0, 1, 1, 0,  0,  0,     0,     0, 1, 0};
    tbl[3]  = '{0, 1, 2, 1,  0,  'h101, 0,     1, 1, 0};
    tbl[4]  = '{0, 1, 3, 2,  11, 'h102, 'h10B, 1, 1, 0};
    tbl[5]  = '{0, 0, 0, 3,  12, 'h103, 'h10C, 1, 1, 0};
    tbl[6]  = '{0, 0, 0, 4,  13, 'h104, 'h10D, 1, 1, 0};
    tbl[7]  = '{0, 0, 0, 0,  14, 0,     'h10E, 1, 1, 0};
    for (int c = 8; c <= 11; c++) tbl[c] = '{0, 0, 0, 0, 0, 0, 0, 1, 1, 0};
    tbl[12] = '{0, 0, 0, 0,  0,  0,     0,     0, 0, 1};
    tbl[13] = '{0, 0, 0, 0,  0,  0,     0,     0, 0, 0};

    // Reset with random START and ROM data.
    rand_rom  = 1'b1;
    RST_N     = 1'b0;
    ifa.START = 1'b0;
    ifb.START = 1'b0;
    ifc.START = 1'b0;
    repeat (4) begin
      @(posedge CLK);
      #1;
      ifa.START = 1'($urandom_range(0, 1));
      ifb.START = 1'($urandom_range(0, 1));
      ifc.START = 1'($urandom_range(0, 1));
    end
    @(negedge CLK);
    chk_zero("in_reset");
    RST_N     = 1'b1;
    rand_rom  = 1'b0;
    ifa.START = 1'b0;
    ifb.START = 1'b0;
    ifc.START = 1'b0;
    repeat (5) @(posedge CLK);
    @(negedge CLK);
    chk_zero("post_reset");

    // Basic run.
    run_table("basic");

    // START held high for 30 cycles: two complete runs.
    fetch2 = -1;
    for (int c = 0; c < 30; c++) begin
      @(posedge CLK);
      #1 ifa.START = 1'b1;
      @(negedge CLK);
      if (ifa.DONE) done_cyc.push_back(c);
      if (ifa.ROM_EN) begin
        addrs.push_back(int'(ifa.ROM_ADDR));
        if (fetch2 < 0 && done_cyc.size() == 1) fetch2 = c;
      end
    end
    @(posedge CLK);
    #1 ifa.START = 1'b0;
    chk("multi done count", 128'(done_cyc.size()), 128'(2));
    if (done_cyc.size() >= 2) begin
      chk("multi done1 cycle", 128'(done_cyc[0]), 128'(12));
      chk("multi done2 cycle", 128'(done_cyc[1]), 128'(25));
    end
    chk("multi second fetch cycle", 128'(fetch2), 128'(14));
    chk("multi addr count", 128'(addrs.size() >= 8), 128'(1));
    for (int k = 0; k < 8 && k < addrs.size(); k++)
      chk($sformatf("multi addr%0d", k), 128'(addrs[k]), 128'(k % 4));

    @(negedge CLK) RST_N = 1'b0;
    @(negedge CLK) RST_N = 1'b1;

    // Reset in the middle of a run.
    @(posedge CLK);
    #1 ifa.START = 1'b1;
    @(posedge CLK);
    #1 ifa.START = 1'b0;
    repeat (4) @(posedge CLK);
    #1 chk("midrun pre-reset wt", 128'(ifa.WT_OUT), 128'({16'd12, 16'd3}));
    #1 RST_N = 1'b0;
    #1 chk_zero("midrun reset");
    activity = 0;
    repeat (2) begin
      @(negedge CLK);
      if (ifa.DONE || ifa.BUSY || ifa.ARRAY_EN) activity++;
    end
    RST_N = 1'b1;
    repeat (20) begin
      @(negedge CLK);
      if (ifa.DONE || ifa.BUSY || ifa.ARRAY_EN) activity++;
    end
    chk("midrun no activity after reset", 128'(activity), 128'(0));
    run_table("rerun");

    // 4x3 array, DEPTH=1, all-ones ROM.
    for (int c = 0; c <= 16; c++) begin
      @(posedge CLK);
      #1 ifb.START = (c == 0);
      @(negedge CLK);
      for (int n = 0; n < 4; n++)
        chk($sformatf("cfgB c%0d wt%0d", c, n), 128'(ifb.WT_OUT[16*n +: 16]),
            128'((c == 3 + n) ? 16'hFFFF : 16'h0000));
      for (int n = 0; n < 3; n++)
        chk($sformatf("cfgB c%0d in%0d", c, n), 128'(ifb.IN_OUT[16*n +: 16]),
            128'((c == 3 + n) ? 16'hFFFF : 16'h0000));
      chk($sformatf("cfgB c%0d array_en", c), 128'(ifb.ARRAY_EN), 128'(c >= 3 && c <= 14));
      chk($sformatf("cfgB c%0d busy", c), 128'(ifb.BUSY), 128'(c >= 1 && c <= 14));
      chk($sformatf("cfgB c%0d done", c), 128'(ifb.DONE), 128'(c == 15));
    end

    // ADDR_W=2 with DEPTH=4: full address space, no wrap glitch.
    for (int c = 0; c <= 13; c++) begin
      @(posedge CLK);
      #1 ifc.START = (c == 0);
      @(negedge CLK);
      chk($sformatf("cfgC c%0d rom_en", c), 128'(ifc.ROM_EN), 128'(c >= 1 && c <= 4));
      chk($sformatf("cfgC c%0d addr", c), 128'(ifc.ROM_ADDR),
          128'((c >= 1 && c <= 4) ? c - 1 : 0));
      chk($sformatf("cfgC c%0d done", c), 128'(ifc.DONE), 128'(c == 12));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
